glb_ifmap_dispatcher: RTL and testbench

Streams ifmap pixels from the global buffer into the PE array bus for row-stationary convolution. It is the parametrised successor of the single-channel, fixed-geometry buffer writer. It adds runtime ifmap width, height and channel count, valid/ready backpressure on both sides, and a decoupling FIFO. Each pixel is tagged with row, column and channel, plus a per-PE-row multicast mask, so the PE set can latch only what each row needs.

---
 rtl/glb_pkg.sv | 52 +++++
 rtl/glb_sync_fifo.sv | 61 ++++++
 rtl/glb_ifmap_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_glb_ifmap_dispatcher.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pkg.sv
// Shared types and helpers for the GLB ifmap dispatcher.
//   disp_state_t : dispatcher FSM states
//   disp_word_t  : one tagged pixel as it travels through the output FIFO
//   row_mask()   : which PE rows consume a pixel of a given ifmap row
package glb_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 16;
  localparam int unsigned NUM_ROW_DEFAULT    = 4;
  localparam int unsigned MAX_K_DEFAULT      = 7;
  localparam int unsigned DIM_WIDTH_DEFAULT  = 8;
  localparam int unsigned CH_WIDTH_DEFAULT   = 8;

  // One extra bit so row-i and H-K never wrap.
  localparam int unsigned MASK_CALC_W = DIM_WIDTH_DEFAULT + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } disp_state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] data;
    logic [DIM_WIDTH_DEFAULT-1:0]  row;
    logic [DIM_WIDTH_DEFAULT-1:0]  col;
    logic [CH_WIDTH_DEFAULT-1:0]   ch;
    logic [NUM_ROW_DEFAULT-1:0]    mask;
    logic                          last;
  } disp_word_t;

  // PE row i uses ifmap row r when kernel row i lands on r for some valid output row,
  // i.e. i < K, i <= r and r - i <= H - K. Rows beyond NUM_ROW are simply not produced.
  function automatic logic [NUM_ROW_DEFAULT-1:0] row_mask(
    input logic [DIM_WIDTH_DEFAULT-1:0] row,
    input logic [7:0]                   k,
    input logic [DIM_WIDTH_DEFAULT-1:0] h
  );
    logic [MASK_CALC_W-1:0]     rx, kx, hx, ix;
    logic [NUM_ROW_DEFAULT-1:0] m;
    rx = {1'b0, row};
    kx = MASK_CALC_W'(k);
    hx = {1'b0, h};
    m  = '0;
    for (int unsigned i = 0; i < NUM_ROW_DEFAULT; i++) begin
      ix   = MASK_CALC_W'(i);
      m[i] = (ix < kx) && (ix <= rx) && ((rx - ix) <= (hx - kx));
    end
    return m;
  endfunction

endpackage

// File: rtl/glb_sync_fifo.sv
// First-word-fall-through synchronous FIFO of disp_word_t.
//   clk, rstn      : clock, async active-low reset
//   clear          : sync empty (wins over push/pop)
//   push, wdata    : write side; push ignored when full
//   pop, rdata     : read side; rdata is the head word whenever !empty
//   full, empty, count : occupancy status
module glb_sync_fifo
  import glb_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  disp_word_t               wdata,
  input  logic                     pop,
  output disp_word_t               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  disp_word_t      mem [Depth];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage carries no reset; consumers gate the head word with !empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/glb_ifmap_dispatcher.sv
// Streams ifmap pixels from the global buffer onto the PE array bus, tagging each with
// row/col/channel and the mask of PE rows that need it.
//   start, cfg_*        : frame launch and geometry (K, W, H, C), latched on start
//   flush               : sync abort back to idle, drops queued words
//   in_valid/ready/data : pixel stream from the global buffer (col, row, ch order)
//   out_*               : tagged pixel stream to the PE set, valid/ready
//   busy, done, cfg_err : frame status; done and cfg_err are one-cycle pulses
module glb_ifmap_dispatcher
  import glb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned NUM_ROW    = NUM_ROW_DEFAULT,
  parameter int unsigned MAX_K      = MAX_K_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIM_WIDTH  = DIM_WIDTH_DEFAULT,
  parameter int unsigned CH_WIDTH   = CH_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  start,
  input  logic [7:0]            cfg_kernel_size,
  input  logic [DIM_WIDTH-1:0]  cfg_ifmap_w,
  input  logic [DIM_WIDTH-1:0]  cfg_ifmap_h,
  input  logic [CH_WIDTH-1:0]   cfg_channels,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DIM_WIDTH-1:0]  out_row,
  output logic [DIM_WIDTH-1:0]  out_col,
  output logic [CH_WIDTH-1:0]   out_ch,
  output logic [NUM_ROW-1:0]    out_row_mask,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  disp_state_t            state_q;
  logic [7:0]             k_q;
  logic [DIM_WIDTH-1:0]   w_q, h_q, row_q, col_q;
  logic [CH_WIDTH-1:0]    c_q, ch_q;
  logic                   cfg_err_q;

  logic                   push, pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                   col_end, row_end, ch_end, frame_end, cfg_ok;
  disp_word_t             wr_word, rd_word;

  assign cfg_ok = (cfg_kernel_size != '0) && (32'(cfg_kernel_size) <= MAX_K) &&
                  (32'(cfg_kernel_size) <= 32'(cfg_ifmap_w)) &&
                  (32'(cfg_kernel_size) <= 32'(cfg_ifmap_h)) &&
                  (cfg_ifmap_w != '0) && (cfg_ifmap_h != '0) && (cfg_channels != '0);

  assign col_end   = (col_q == w_q - DIM_WIDTH'(1));
  assign row_end   = (row_q == h_q - DIM_WIDTH'(1));
  assign ch_end    = (ch_q == c_q - CH_WIDTH'(1));
  assign frame_end = col_end && row_end && ch_end;

  assign in_ready = (state_q == StRun) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    wr_word      = '0;
    wr_word.data = in_data;
    wr_word.row  = row_q;
    wr_word.col  = col_q;
    wr_word.ch   = ch_q;
    wr_word.mask = row_mask(row_q, k_q, h_q);
    wr_word.last = frame_end;
  end

  glb_sync_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .push  (push),
    .wdata (wr_word),
    .pop   (pop),
    .rdata (rd_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      k_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      c_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ch_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (flush) begin
        state_q <= StIdle;
        row_q   <= '0;
        col_q   <= '0;
        ch_q    <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (cfg_ok) begin
                k_q     <= cfg_kernel_size;
                w_q     <= cfg_ifmap_w;
                h_q     <= cfg_ifmap_h;
                c_q     <= cfg_channels;
                row_q   <= '0;
                col_q   <= '0;
                ch_q    <= '0;
                state_q <= StRun;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          StRun: begin
            if (push) begin
              if (col_end) begin
                col_q <= '0;
                if (row_end) begin
                  row_q <= '0;
                  ch_q  <= ch_end ? '0 : ch_q + 1'b1;
                end else begin
                  row_q <= row_q + 1'b1;
                end
              end else begin
                col_q <= col_q + 1'b1;
              end
              if (frame_end) state_q <= StDrain;
            end
          end
          StDrain: begin
            if (fifo_count == '0) state_q <= StDone;
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign cfg_err = cfg_err_q;

  // FIFO storage is not reset, so hold the bus at zero whenever nothing is queued.
  assign out_valid    = !fifo_empty;
  assign out_data     = out_valid ? rd_word.data : '0;
  assign out_row      = out_valid ? rd_word.row  : '0;
  assign out_col      = out_valid ? rd_word.col  : '0;
  assign out_ch       = out_valid ? rd_word.ch   : '0;
  assign out_row_mask = out_valid ? rd_word.mask : '0;
  assign out_last     = out_valid && rd_word.last;

endmodule

// File: tb/tb_glb_ifmap_dispatcher.sv
module tb_glb_ifmap_dispatcher;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush, start;
  logic [7:0]  cfg_kernel_size, cfg_ifmap_w, cfg_ifmap_h, cfg_channels;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_row, out_col, out_ch;
  logic [3:0]  out_row_mask;
  logic        out_last, busy, done, cfg_err;

  int n_vec = 0;
  int n_err = 0;

  // Row masks packed 4 bits per ifmap row, row 0 in the low nibble.
  localparam logic [15:0] MasksK3H4 = 16'h4631; // 0001 0011 0110 0100
  localparam logic [15:0] MasksK1   = 16'h1111;

  glb_ifmap_dispatcher dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush           (flush),
    .start           (start),
    .cfg_kernel_size (cfg_kernel_size),
    .cfg_ifmap_w     (cfg_ifmap_w),
    .cfg_ifmap_h     (cfg_ifmap_h),
    .cfg_channels    (cfg_channels),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_row         (out_row),
    .out_col         (out_col),
    .out_ch          (out_ch),
    .out_row_mask    (out_row_mask),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame with in_data = word index, out_ready low for the first `hold` cycles.
  task automatic run_stream(input string name, input int w, input int h, input int c,
                            input int k, input logic [15:0] masks, input int hold);
    int n_tot, sent, got, cyc, done_cnt, done_cyc, last_pop, acc_hold, r;
    bit acc, have_held, held_ok, finished;
    logic [15:0] held;
    logic [15:0] e_data;
    logic [7:0]  e_row, e_col, e_ch;
    logic [3:0]  e_mask;
    logic        e_last;
    n_tot = w * h * c; sent = 0; got = 0; cyc = 0; done_cnt = 0;
    done_cyc = -10; last_pop = -10; acc_hold = 0;
    have_held = 0; held_ok = 1; finished = 0; held = '0;
    cfg_kernel_size = 8'(k); cfg_ifmap_w = 8'(w); cfg_ifmap_h = 8'(h); cfg_channels = 8'(c);
    in_valid = 1'b0; out_ready = (hold == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    in_valid = 1'b1; in_data = 16'd0;
    while (!finished && cyc < 600) begin
      out_ready = (cyc >= hold);
      if (cyc < hold && out_valid === 1'b1) begin
        if (!have_held) begin held = out_data; have_held = 1; end
        else if (out_data !== held) held_ok = 0;
      end
      if (hold > 0 && cyc == hold) begin
        n_vec++;
        if (acc_hold != 8 || in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s fill_level: got accepts=%0d in_ready=%b want accepts=8 in_ready=0",
                   name, acc_hold, in_ready);
        end
        n_vec++;
        if (!have_held || !held_ok || held !== 16'd0) begin
          n_err++;
          $display("FAIL %s held_data: got stable=%b value=%h want stable=1 value=0000",
                   name, held_ok, held);
        end
      end
      acc = (in_valid === 1'b1) && (in_ready === 1'b1);
      if (acc && cyc < hold) acc_hold++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        e_data = 16'(got);
        e_col  = 8'(got % w);
        r      = (got / w) % h;
        e_row  = 8'(r);
        e_ch   = 8'(got / (w * h));
        e_mask = masks[r*4 +: 4];
        e_last = (got == n_tot - 1);
        n_vec++;
        if ({out_data, out_row, out_col, out_ch, out_row_mask, out_last} !==
            {e_data, e_row, e_col, e_ch, e_mask, e_last}) begin
          n_err++;
          $display("FAIL %s word%0d: got d=%h r=%0d c=%0d ch=%0d m=%b l=%b want d=%h r=%0d c=%0d ch=%0d m=%b l=%b",
                   name, got, out_data, out_row, out_col, out_ch, out_row_mask, out_last,
                   e_data, e_row, e_col, e_ch, e_mask, e_last);
        end
        if (got == n_tot - 1) last_pop = cyc;
        got++;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt > 0 && cyc == done_cyc + 1) begin
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
        end
        finished = 1;
      end
      if (!finished) begin
        tick();
        cyc++;
        if (acc) sent++;
        in_valid = (sent < n_tot);
        in_data  = 16'(sent);
      end
    end
    in_valid = 1'b0;
    if (!finished) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: got no done within 600 cycles, want done", name);
    end
    n_vec++;
    if (got != n_tot) begin
      n_err++; $display("FAIL %s word_count: got %0d want %0d", name, got, n_tot);
    end
    n_vec++;
    if (done_cnt != 1 || done_cyc != last_pop + 2) begin
      n_err++;
      $display("FAIL %s done_timing: got pulses=%0d at cycle %0d want 1 at cycle %0d",
               name, done_cnt, done_cyc, last_pop + 2);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_kernel_size = '0; cfg_ifmap_w = '0; cfg_ifmap_h = '0; cfg_channels = '0;
    repeat (3) tick();
    n_vec++;
    if ({in_ready, out_valid, busy, done, cfg_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_status: got rdy=%b vld=%b busy=%b done=%b err=%b want all 0",
               in_ready, out_valid, busy, done, cfg_err);
    end
    n_vec++;
    if ({out_data, out_row, out_col, out_ch, out_row_mask, out_last} !== '0) begin
      n_err++;
      $display("FAIL reset_bus: got d=%h r=%0d c=%0d ch=%0d m=%b l=%b want all 0",
               out_data, out_row, out_col, out_ch, out_row_mask, out_last);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_stream("basic", 4, 4, 1, 3, MasksK3H4, 0);
  endtask

  task automatic test_channels();
    run_stream("two_ch", 4, 4, 2, 3, MasksK3H4, 0);
  endtask

  task automatic test_back_pressure();
    run_stream("backpressure", 4, 4, 1, 3, MasksK3H4, 20);
  endtask

  task automatic test_cfg_err();
    logic [7:0] ks [2];
    logic [7:0] hs [2];
    ks[0] = 8'd0; hs[0] = 8'd4;
    ks[1] = 8'd5; hs[1] = 8'd8;
    for (int i = 0; i < 2; i++) begin
      cfg_kernel_size = ks[i]; cfg_ifmap_w = 8'd4; cfg_ifmap_h = hs[i]; cfg_channels = 8'd1;
      in_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if ({cfg_err, busy, in_ready} !== 3'b100) begin
        n_err++;
        $display("FAIL cfg_err_k%0d: got err=%b busy=%b rdy=%b want 1 0 0",
                 ks[i], cfg_err, busy, in_ready);
      end
      tick();
      n_vec++;
      if ({cfg_err, busy, in_ready} !== 3'b000) begin
        n_err++;
        $display("FAIL cfg_err_k%0d_pulse: got err=%b busy=%b rdy=%b want 0 0 0",
                 ks[i], cfg_err, busy, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    int acc_n, cyc, done_seen;
    bit a;
    acc_n = 0; cyc = 0; done_seen = 0;
    cfg_kernel_size = 8'd3; cfg_ifmap_w = 8'd4; cfg_ifmap_h = 8'd4; cfg_channels = 8'd1;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A0;
    while (acc_n < 6 && cyc < 50) begin
      a = (in_valid === 1'b1) && (in_ready === 1'b1);
      tick();
      cyc++;
      if (a) begin acc_n++; in_data = in_data + 16'd1; end
    end
    in_valid = 1'b0;
    n_vec++;
    if (acc_n != 6 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_setup: got accepts=%0d vld=%b want 6 1", acc_n, out_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({out_valid, busy, done, in_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL flush_clear: got vld=%b busy=%b done=%b rdy=%b want 0 0 0 0",
               out_valid, busy, done, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (done !== 1'b0 || out_valid !== 1'b0) done_seen++;
      tick();
    end
    n_vec++;
    if (done_seen != 0) begin
      n_err++; $display("FAIL flush_quiet: got %0d active cycles want 0", done_seen);
    end
    run_stream("restart", 4, 4, 1, 3, MasksK3H4, 0);
  endtask

  task automatic test_reset_drain();
    int acc_n, cyc;
    bit a;
    acc_n = 0; cyc = 0;
    cfg_kernel_size = 8'd1; cfg_ifmap_w = 8'd2; cfg_ifmap_h = 8'd2; cfg_channels = 8'd1;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h5A50;
    while (acc_n < 4 && cyc < 50) begin
      a = (in_valid === 1'b1) && (in_ready === 1'b1);
      tick();
      cyc++;
      if (a) begin acc_n++; in_data = in_data + 16'd1; end
    end
    in_valid = 1'b0;
    n_vec++;
    if (acc_n != 4 || {busy, out_valid, in_ready} !== 3'b110) begin
      n_err++;
      $display("FAIL drain_setup: got accepts=%0d busy=%b vld=%b rdy=%b want 4 1 1 0",
               acc_n, busy, out_valid, in_ready);
    end
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_data, out_row, out_col, out_ch, out_row_mask, out_last,
         busy, done, cfg_err} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got rdy=%b vld=%b d=%h m=%b l=%b busy=%b done=%b err=%b want all 0",
               in_ready, out_valid, out_data, out_row_mask, out_last, busy, done, cfg_err);
    end
    tick();
    rstn = 1'b1;
    tick();
    run_stream("post_reset", 2, 2, 1, 1, MasksK1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_channels();
    test_back_pressure();
    test_cfg_err();
    test_flush();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
